// File: rtl/lb_uart_rx_controller.sv
// UART receiver: 16x-tick sampled, LSB first, byte handed to the I/O port with a valid/rd handshake.
// Ports: clk, reset(async, low), tick, rx, rd -> data[7:0], valid, frame_err, parity_err, overrun, busy.
// Optional parity bit: define LB_UART_RX_PARITY_EN.
module lb_uart_rx_controller #(
  parameter int DBIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef LB_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);

  logic       r_rx_m;
  logic       r_rx_s;
  logic       r_rx_p;
  state_t     r_state;
  logic [3:0] r_tc;
  logic [2:0] r_bc;
  logic [7:0] r_sr;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_fe;
  logic       r_pe;
  logic       r_ovr;

  state_t     w_nxt_state;
  logic [3:0] w_nxt_tc;
  logic [2:0] w_nxt_bc;
  logic [7:0] w_nxt_sr;
  logic       w_done;
  logic       w_fall;
  logic       w_perr;
  logic [7:0] w_align;

`ifdef LB_UART_RX_PARITY_EN
  logic r_perr;
  logic w_nxt_perr;
  assign w_perr = r_perr;
`else
  assign w_perr = 1'b0;
`endif

  assign w_fall  = r_rx_p & ~r_rx_s;
  // Data arrives at the top of sr; shift it down so it is LSB-aligned.
  assign w_align = r_sr >> (8 - DBIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_p <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
      r_rx_p <= r_rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tc    <= '0;
      r_bc    <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_tc    <= w_nxt_tc;
      r_bc    <= w_nxt_bc;
      r_sr    <= w_nxt_sr;
    end
  end

`ifdef LB_UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_nxt_perr;
    end
  end
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tc    = r_tc;
    w_nxt_bc    = r_bc;
    w_nxt_sr    = r_sr;
    w_done      = 1'b0;
`ifdef LB_UART_RX_PARITY_EN
    w_nxt_perr  = r_perr;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_nxt_state = S_START;
          w_nxt_tc    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (r_tc == 4'd7) begin
            if (r_rx_s) begin
              w_nxt_state = S_IDLE;
            end else begin
              w_nxt_state = S_DATA;
              w_nxt_tc    = '0;
              w_nxt_bc    = '0;
              // Clear so unused low bits never leak old data.
              w_nxt_sr    = '0;
            end
          end else begin
            w_nxt_tc = r_tc + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          w_nxt_tc = r_tc + 4'd1;
          if (r_tc == 4'd15) begin
            w_nxt_sr = {r_rx_s, r_sr[7:1]};
            if (r_bc == LAST_BIT) begin
`ifdef LB_UART_RX_PARITY_EN
              w_nxt_state = S_PARITY;
`else
              w_nxt_state = S_STOP;
`endif
            end else begin
              w_nxt_bc = r_bc + 3'd1;
            end
          end
        end
      end
`ifdef LB_UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          w_nxt_tc = r_tc + 4'd1;
          if (r_tc == 4'd15) begin
            // Even parity: ones in data plus parity bit must be even.
            w_nxt_perr  = ^{r_sr, r_rx_s};
            w_nxt_state = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          w_nxt_tc = r_tc + 4'd1;
          if (r_tc == 4'd15) begin
            w_nxt_state = S_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      r_data  <= w_align;
      r_valid <= 1'b1;
      r_fe    <= ~r_rx_s;
      r_pe    <= w_perr;
      // A coincident rd consumes the old byte, so nothing is lost.
      if (r_valid && !rd) begin
        r_ovr <= 1'b1;
      end else if (r_valid && rd) begin
        r_ovr <= 1'b0;
      end
    end else if (rd && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_fe;
  assign parity_err = r_pe;
  assign overrun    = r_ovr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_lb_uart_rx_controller.sv
// Directed bench for lb_uart_rx_controller: 8-bit frames, tick every 4 clk.
// Parity cases run only when LB_UART_RX_PARITY_EN is defined.
module tb_lb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  logic [1:0] tcnt = 2'd0;
  int n_chk = 0;
  int n_err = 0;
  logic seen;

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick = (tcnt == 2'd3);

  lb_uart_rx_controller #(.DBIT(8)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .rx(rx),
    .rd(rd),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 rx = b;
    repeat (63) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb,
                            input logic pb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef LB_UART_RX_PARITY_EN
    send_bit(pb);
`else
    if (pb) begin end
`endif
    send_bit(stopb);
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ovr", {7'd0, overrun}, 8'd0);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clk);
    chk("a5_data", data, 8'hA5);
    chk("a5_valid", {7'd0, valid}, 8'd1);
    chk("a5_fe", {7'd0, frame_err}, 8'd0);
    chk("a5_pe", {7'd0, parity_err}, 8'd0);
    pulse_rd();
    @(negedge clk);
    chk("a5_rd_valid", {7'd0, valid}, 8'd0);

    repeat (30) @(posedge clk);
    #1 rx = 1'b0;
    repeat (12) @(posedge clk);
    #1 rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("gl_busy_seen", {7'd0, seen}, 8'd1);
    chk("gl_busy", {7'd0, busy}, 8'd0);
    chk("gl_valid", {7'd0, valid}, 8'd0);

    send_frame(8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    chk("3c_data", data, 8'h3C);
    chk("3c_fe", {7'd0, frame_err}, 8'd1);
    chk("3c_valid", {7'd0, valid}, 8'd1);
    pulse_rd();
    repeat (400) @(posedge clk);
    @(negedge clk);
    chk("low_valid", {7'd0, valid}, 8'd0);
    chk("low_busy", {7'd0, busy}, 8'd0);
    #1 rx = 1'b1;
    repeat (64) @(posedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    @(negedge clk);
    chk("81_data", data, 8'h81);
    chk("81_fe", {7'd0, frame_err}, 8'd0);
    pulse_rd();

    repeat (40) @(posedge clk);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    chk("ov_data", data, 8'h22);
    chk("ov_valid", {7'd0, valid}, 8'd1);
    chk("ov_ovr", {7'd0, overrun}, 8'd1);
    pulse_rd();
    @(negedge clk);
    chk("ov_rd_valid", {7'd0, valid}, 8'd0);
    chk("ov_rd_ovr", {7'd0, overrun}, 8'd0);

    repeat (40) @(posedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (32) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_data", data, 8'h00);
    chk("mid_valid", {7'd0, valid}, 8'd0);
    chk("mid_busy", {7'd0, busy}, 8'd0);
    chk("mid_fe", {7'd0, frame_err}, 8'd0);
    chk("mid_ovr", {7'd0, overrun}, 8'd0);
    #1 reset = 1'b1;
    repeat (100) @(posedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    chk("5a_data", data, 8'h5A);
    chk("5a_valid", {7'd0, valid}, 8'd1);
    chk("5a_fe", {7'd0, frame_err}, 8'd0);
    chk("5a_ovr", {7'd0, overrun}, 8'd0);
    pulse_rd();

`ifdef LB_UART_RX_PARITY_EN
    repeat (40) @(posedge clk);
    send_frame(8'h07, 1'b1, 1'b1);
    @(negedge clk);
    chk("p1_data", data, 8'h07);
    chk("p1_pe", {7'd0, parity_err}, 8'd0);
    pulse_rd();
    repeat (40) @(posedge clk);
    send_frame(8'h07, 1'b1, 1'b0);
    @(negedge clk);
    chk("p0_data", data, 8'h07);
    chk("p0_pe", {7'd0, parity_err}, 8'd1);
    pulse_rd();
`endif

    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
